// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment readback path: active-low segment
// patterns (bit 0 = a ... bit 6 = g), the all-off blank pattern and FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_COMPARE = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one active-low seven-segment pattern to a nibble.
// SEG7_SCAN_BLANK_EN adds the blank_c output for the all-off pattern.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_c,
  output logic       err_c
`ifdef SEG7_SCAN_BLANK_EN
  ,
  output logic       blank_c
`endif
);

  always_comb begin
    nibble_c = 4'h0;
    err_c    = 1'b0;
`ifdef SEG7_SCAN_BLANK_EN
    blank_c  = 1'b0;
`endif
    case (seg_i)
      SEG_0: nibble_c = 4'h0;
      SEG_1: nibble_c = 4'h1;
      SEG_2: nibble_c = 4'h2;
      SEG_3: nibble_c = 4'h3;
      SEG_4: nibble_c = 4'h4;
      SEG_5: nibble_c = 4'h5;
      SEG_6: nibble_c = 4'h6;
      SEG_7: nibble_c = 4'h7;
      SEG_8: nibble_c = 4'h8;
      SEG_9: nibble_c = 4'h9;
      SEG_A: nibble_c = 4'hA;
      SEG_B: nibble_c = 4'hB;
      SEG_C: nibble_c = 4'hC;
      SEG_D: nibble_c = 4'hD;
      SEG_E: nibble_c = 4'hE;
      SEG_F: nibble_c = 4'hF;
`ifdef SEG7_SCAN_BLANK_EN
      SEG_BLANK: blank_c = 1'b1;
`endif
      default: err_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Scans a bank of seven-segment drives back into nibbles, filters for stability
// and offers each stable, changed word on valid/ready. Option: SEG7_SCAN_BLANK_EN.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 6,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7*NUM_DIGITS-1:0]   seg_in,
  input  logic                      sample_en,
  output logic [4*NUM_DIGITS-1:0]   out_value,
  output logic [NUM_DIGITS-1:0]     out_err_mask,
  output logic [NUM_DIGITS-1:0]     out_blank_mask,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
`ifdef SEG7_SCAN_BLANK_EN
  localparam int unsigned ERR_LSB = NUM_DIGITS;
  localparam int unsigned VAL_LSB = 2 * NUM_DIGITS;
`else
  localparam int unsigned ERR_LSB = 0;
  localparam int unsigned VAL_LSB = NUM_DIGITS;
`endif
  // Word layout, MSB first: {value, err mask, [blank mask]}.
  localparam int unsigned WORD_W  = VAL_LSB + 4 * NUM_DIGITS;

  state_e                    state_q, state_d;
  logic [7*NUM_DIGITS-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [WORD_W-1:0]         work_q, work_d;
  logic [WORD_W-1:0]         prev_q, prev_d;
  logic [WORD_W-1:0]         last_q, last_d;
  logic                      have_prev_q, have_prev_d;
  logic                      reported_q, reported_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      valid_q, valid_d;

  logic [6:0]                dig_seg_c;
  logic [3:0]                dig_nib_c;
  logic                      dig_err_c;
`ifdef SEG7_SCAN_BLANK_EN
  logic                      dig_blank_c;
`endif
  logic                      same_c;
  logic                      emit_c;
  logic [3:0]                cnt_nxt_c;

  assign dig_seg_c = snap_q[7*int'(idx_q) +: 7];

  seg7_digit_decode u_dec (
    .seg_i    (dig_seg_c),
    .nibble_c (dig_nib_c),
    .err_c    (dig_err_c)
`ifdef SEG7_SCAN_BLANK_EN
    ,
    .blank_c  (dig_blank_c)
`endif
  );

  // Stability filter: count repeats of the just-assembled word and decide on emit.
  always_comb begin
    same_c = have_prev_q && (work_q == prev_q);
    if (!same_c) begin
      cnt_nxt_c = 4'd1;
    end else if (cnt_q >= 4'(STABLE_CYCLES)) begin
      cnt_nxt_c = 4'(STABLE_CYCLES);
    end else begin
      cnt_nxt_c = cnt_q + 4'd1;
    end
    emit_c = (cnt_nxt_c == 4'(STABLE_CYCLES)) && (!reported_q || (work_q != last_q));
  end

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    work_d      = work_q;
    prev_d      = prev_q;
    last_d      = last_q;
    have_prev_d = have_prev_q;
    reported_d  = reported_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (sample_en) begin
          snap_d  = seg_in;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        work_d[VAL_LSB + 4*int'(idx_q) +: 4] = dig_nib_c;
        work_d[ERR_LSB + int'(idx_q)]        = dig_err_c;
`ifdef SEG7_SCAN_BLANK_EN
        work_d[int'(idx_q)]                  = dig_blank_c;
`endif
        if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
          state_d = ST_COMPARE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_COMPARE: begin
        cnt_d       = cnt_nxt_c;
        prev_d      = work_q;
        have_prev_d = 1'b1;
        if (emit_c) begin
          last_d     = work_q;
          reported_d = 1'b1;
          valid_d    = 1'b1;
          state_d    = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      snap_q      <= '0;
      idx_q       <= '0;
      work_q      <= '0;
      prev_q      <= '0;
      last_q      <= '0;
      have_prev_q <= 1'b0;
      reported_q  <= 1'b0;
      cnt_q       <= 4'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      work_q      <= work_d;
      prev_q      <= prev_d;
      last_q      <= last_d;
      have_prev_q <= have_prev_d;
      reported_q  <= reported_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
    end
  end

  // The last reported word doubles as the output register.
  assign out_value    = last_q[VAL_LSB +: 4*NUM_DIGITS];
  assign out_err_mask = last_q[ERR_LSB +: NUM_DIGITS];
`ifdef SEG7_SCAN_BLANK_EN
  assign out_blank_mask = last_q[0 +: NUM_DIGITS];
`else
  assign out_blank_mask = '0;
`endif
  assign out_valid = valid_q;

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Reverse of the hex-to-seven-segment encoder: samples the segment drive of a bank of seven-segment digits and decodes each active-low pattern back to a 4-bit nibble. Digits are scanned one per cycle. Each assembled word goes through a stability filter, and only a stable, changed word is offered downstream on a valid/ready handshake. Used in the text-editor datapath for display readback and self-check of the HEX outputs.

## Interface
- NUM_DIGITS, 6, number of digits scanned (1–8)
- STABLE_CYCLES, 4, consecutive identical scans required before a word is reported (1–15)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- seg_in  in  7*NUM_DIGITS  segment drive; digit i in bits [7i+6:7i]; bit 0 = segment a … bit 6 = segment g; active-low (0 = lit)
- sample_en  in  1  starts one scan when accepted in IDLE
- out_value  out  4*NUM_DIGITS  decoded nibbles; digit i in bits [4i+3:4i]
- out_err_mask  out  NUM_DIGITS  bit i set: digit i pattern not in decode table
- out_blank_mask  out  NUM_DIGITS  bit i set: digit i all-off (0x7F); constant 0 without macro
- out_valid  out  1  word available
- out_ready  in  1  consumer accepts word when high with out_valid

## Operation
- Decode table (seg_in slice, hex → nibble): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F. Any other pattern: nibble 0, error bit 1.
- FSM states: IDLE, SCAN, COMPARE, HOLD.
- IDLE: when sample_en=1, register the whole seg_in into a snapshot, clear digit index, go to SCAN. sample_en is ignored in all other states.
- SCAN: decode snapshot digit `idx` into the working word, one digit per cycle. After digit NUM_DIGITS-1, go to COMPARE.
- COMPARE: compare working {value, err, blank} with the previous scan.
  - Equal: stable_cnt increments, saturating at STABLE_CYCLES.
  - Not equal, or first scan since reset: stable_cnt = 1.
  - Store the working word as the previous scan.
  - Emit if stable_cnt reaches STABLE_CYCLES in this cycle AND (nothing reported since reset OR word ≠ last reported word). On emit: load outputs, record last reported word, go to HOLD. Otherwise go to IDLE.
- HOLD: out_valid=1 and outputs held stable until out_ready=1. On that handshake cycle, out_valid drops next cycle and the FSM goes to IDLE.
- Reset (any state, including mid-scan or HOLD): state IDLE; out_value, out_err_mask, out_blank_mask, out_valid = 0; stable_cnt = 0; snapshot and previous word = 0; reported flag cleared.

## Timing
- sample_en high at edge t in IDLE → SCAN during cycles t+1…t+NUM_DIGITS → COMPARE at t+NUM_DIGITS+1 → out_valid high from t+NUM_DIGITS+2 if emitted.
- Scan period: NUM_DIGITS+2 cycles minimum (sample_en held high continuously).
- seg_in changes after the snapshot edge do not affect the scan in progress.
- out_ready high while out_valid is low has no effect.
- out_ready held high: HOLD lasts exactly one cycle.

## Configuration
- SEG7_SCAN_BLANK_EN defined: pattern 0x7F decodes to nibble 0, err bit 0, blank bit 1.
- SEG7_SCAN_BLANK_EN undefined: 0x7F is an ordinary error pattern; out_blank_mask is constant 0 and its logic is removed.

## Structure
- Package seg7_pkg holds the 16 segment-pattern constants, the blank pattern constant, and the FSM state enum typedef.
- Sub-module seg7_digit_decode: combinational, 7-bit pattern in → nibble, err, blank out. Instanced once and muxed by idx.

## Test plan
- All 16 patterns on digit 0, STABLE_CYCLES=1: each decodes to its nibble; err=0; out_valid appears 8 cycles after sample_en (NUM_DIGITS=6).
- seg_in = 79,24,30,19,12,02 (digit0…5), STABLE_CYCLES=4, sample_en held high: exactly one word 0x654321 emitted after the 4th scan; no further emits while unchanged.
- Digit 2 = 0x7F: without macro err_mask=000100; with SEG7_SCAN_BLANK_EN blank_mask=000100, err_mask=0.
- Digit 0 toggles between two patterns every scan: stable_cnt never exceeds 1 and out_valid stays low.
- out_ready held low for 20 cycles in HOLD: outputs constant, sample_en pulses ignored; ready=1 → out_valid low next cycle, FSM in IDLE.
- reset asserted in cycle 3 of SCAN: next cycle all outputs 0 and FSM in IDLE. First subsequent stable word is emitted even if it equals the pre-reset report.
